// File: rtl/trn_pkg.sv
// Shared types and helpers for the true-random fetch front end.
package trn_pkg;

    localparam int TRN_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAPT = 2'd2
    } trn_state_e;

    // Number of OUT_W-bit slices served from one 128-bit word.
    function automatic int slices(input int out_w);
        return TRN_W / out_w;
    endfunction

    // Elaboration-time legality check for the slice width.
    function automatic bit out_w_ok(input int out_w);
        return (out_w > 0) && (out_w <= TRN_W) && ((TRN_W % out_w) == 0);
    endfunction

endpackage

// File: rtl/trn_fifo.sv
// DEPTH x 128-bit synchronous FIFO holding accepted random words.
// The head entry is presented combinationally; flush empties it in one edge.
module trn_fifo
    import trn_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [TRN_W-1:0]        wr_data,
    output logic [TRN_W-1:0]        head,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("trn_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [TRN_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    // Pointers wrap naturally because DEPTH is a power of two; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only observed through a non-zero level, so no reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign head  = mem[rd_ptr];
    assign level = count;

    // The fetch side reserves a slot before requesting, so a full FIFO never sees a push.
    push_never_full: assert property (@(posedge clk) disable iff (!rst)
        !(push && !flush && (count == LVL_W'(DEPTH))));

endmodule

// File: rtl/trn_fetch.sv
// Consumer-side front end for the 128-bit TRNG: requests words, health-tests
// them with a repetition count, buffers them and serves OUT_W-bit slices.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for buffer room (level + inflight < DEPTH), no fail/flush
//   REQ   | rng_update high for one cycle; RNG loads a new word at the edge
//   CAPT  | rng_trn valid: run the health test, push the word unless tripped
module trn_fetch
    import trn_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int OUT_W     = 32,
    parameter int REP_LIMIT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    rng_update,
    input  logic [TRN_W-1:0]        rng_trn,
    input  logic                    flush,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    fail
);

    localparam int SL     = slices(OUT_W);
    localparam int IDX_W  = (SL > 1) ? $clog2(SL) : 1;
    localparam int REP_W  = $clog2(REP_LIMIT + 1);
    localparam int LVL_W  = $clog2(DEPTH) + 1;
    localparam int CMT_W  = LVL_W + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SL - 1);
    localparam logic [REP_W-1:0] REP_TRIP = REP_W'(REP_LIMIT);

    if (!out_w_ok(OUT_W)) begin : g_bad_out_w
        $error("trn_fetch: OUT_W must divide 128");
    end

    if (REP_LIMIT < 2) begin : g_bad_rep_limit
        $error("trn_fetch: REP_LIMIT must be at least 2");
    end

    trn_state_e       state;
    trn_state_e       state_nxt;
    logic [TRN_W-1:0] prev;
    logic             prev_valid;
    logic [REP_W-1:0] rep;
    logic [REP_W-1:0] rep_nxt;
    logic [IDX_W-1:0] idx;
    logic [TRN_W-1:0] head;
    logic [OUT_W-1:0] slice_arr [SL];
    logic [CMT_W-1:0] committed;
    logic             inflight;
    logic             can_fetch;
    logic             trip;
    logic             push;
    logic             xfer;
    logic             slice_last;
    logic             fifo_pop;

    // A request counts against buffer room from REQ until its capture completes.
    assign inflight  = (state == REQ) || (state == CAPT);
    assign committed = {1'b0, level} + {{LVL_W{1'b0}}, inflight};
    assign can_fetch = committed < CMT_W'(DEPTH);

    assign rep_nxt = (prev_valid && (rng_trn == prev)) ? rep + 1'b1 : REP_W'(1);
    assign trip    = (rep_nxt >= REP_TRIP);

    // A capture coinciding with flush is discarded entirely.
    assign push = (state == CAPT) && !flush && !trip;

    assign out_valid  = (level != '0);
    assign xfer       = out_valid && out_ready;
    assign slice_last = (idx == IDX_LAST);
    assign fifo_pop   = xfer && slice_last;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and the one-cycle RNG request strobe.
    always_comb begin
        state_nxt  = state;
        rng_update = 1'b0;
        case (state)
            IDLE: begin
                if (can_fetch && !fail && !flush) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                rng_update = 1'b1;
                state_nxt  = CAPT;
            end
            CAPT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    // Repetition-count health test; fail is sticky until reset and freezes fetching.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev       <= '0;
            prev_valid <= 1'b0;
            rep        <= '0;
            fail       <= 1'b0;
        end else if ((state == CAPT) && !flush) begin
            prev       <= rng_trn;
            prev_valid <= 1'b1;
            rep        <= rep_nxt;
            if (trip) begin
                fail <= 1'b1;
            end
        end
    end

    // Slice index into the head word; wraps to 0 when the head entry is popped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (flush) begin
            idx <= '0;
        end else if (xfer) begin
            idx <= slice_last ? '0 : idx + 1'b1;
        end
    end

    // Split the head word into slices, LSB slice first.
    always_comb begin
        for (int i = 0; i < SL; i++) begin
            slice_arr[i] = head[i*OUT_W +: OUT_W];
        end
    end

    // Present the current slice; zero while the buffer is empty.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            out_data = slice_arr[idx];
        end
    end

    trn_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (fifo_pop),
        .flush   (flush),
        .wr_data (rng_trn),
        .head    (head),
        .level   (level)
    );

endmodule

// File: doc/trn_fetch.md
# trn_fetch

Consumer-side front end for the 128-bit true-random source: it pulses the source's `update` request, captures each fresh 128-bit word and runs a repetition-count health test on it. Accepted words go into a small FIFO. The block then serves them to crypto datapaths (sampler, nonce/salt generation) as OUT_W-bit slices over a valid/ready stream. It sits between the RNG and every randomness consumer, so it is the only block that drives the RNG's `update`.

## Interface
- DEPTH, 4, FIFO entries of 128 bits; power of two, ≥2
- OUT_W, 32, output slice width; must divide 128 (8, 16, 32, 64, 128)
- REP_LIMIT, 3, consecutive identical 128-bit captures that trip the health test; ≥2

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- rng_update  out  1  request to RNG; the RNG loads a new TRN on the clk edge ending the cycle in which this is high
- rng_trn  in  128  RNG output word; valid the cycle after a rng_update cycle
- flush  in  1  synchronous clear of buffered randomness
- out_data  out  OUT_W  current slice of the FIFO head entry
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts; a transfer occurs when out_valid & out_ready
- level  out  $clog2(DEPTH)+1  number of full 128-bit entries in the FIFO
- fail  out  1  sticky health-test failure

## Operation
- Reset values: rng_update=0, out_valid=0, out_data=0, level=0, fail=0, FSM=IDLE, slice index=0, rep count=0, prev_valid=0.
- FSM states:
  - IDLE: go to REQ when `level + inflight < DEPTH`, `!fail` and `!flush`.
  - REQ: drive rng_update=1 for exactly one cycle, then go to CAPT.
  - CAPT: sample rng_trn, run the health test, then go to IDLE.
- inflight = 1 while the FSM is in REQ or CAPT.
- Health test, applied in CAPT:
  - If prev_valid and rng_trn == prev, increment rep; otherwise set rep=1.
  - Set prev=rng_trn and prev_valid=1.
  - If rep reaches REP_LIMIT: set fail=1, do not push the word, and hold the FSM in IDLE until reset.
  - Otherwise push the word into the FIFO.
- Words pushed before a failure stay drainable after it.
- Output slicing:
  - out_data = head[OUT_W*idx +: OUT_W], with idx starting at 0, so the LSB slice goes first.
  - Each transfer increments idx.
  - On the transfer of slice 128/OUT_W−1, pop the head and set idx=0.
- out_valid = (level != 0).
- A push and a pop in the same cycle are both honoured, and level is unchanged.
- Push while full cannot occur, because of the inflight accounting; assert it in simulation.
- flush, on the next edge:
  - level=0, idx=0, FSM→IDLE.
  - A capture in progress is discarded: no push, prev and rep unchanged.
  - fail is not cleared.
  - flush dominates any simultaneous push or pop.
- Reset asserted mid-operation returns every register to its reset value immediately (asynchronously). rng_update falls in the same instant.

## Timing
- Edge E0 is the first edge after rst deasserts. FSM states by cycle after E0:
  - Cycle 0: IDLE.
  - Cycle 1: REQ, rng_update=1.
  - Cycle 2: CAPT.
  - Cycle 3: out_valid=1 and level=1.
- Steady-state fill rate is one 128-bit word per 3 cycles.
- Latency from push to out_valid is 1 cycle. out_data is combinational from the FIFO head register and idx.
- out_valid never drops without a transfer, except on flush or reset. out_data is stable while out_valid & !out_ready.
- fail rises the cycle after the CAPT that trips the test.

## Structure
- Package trn_pkg:
  - FSM state enum {IDLE, REQ, CAPT}.
  - TRN_W=128.
  - Function SLICES(OUT_W)=128/OUT_W.
  - Elaboration check that OUT_W divides 128.
- Sub-module trn_fifo: synchronous FIFO, DEPTH×128, with push, pop, flush, level, and a head output. Pointer wrap is modulo DEPTH.
- trn_fetch holds the FSM, health test and slicer.

## Test plan
- Stub RNG returns 128'h0123…EF, 128'hFEDC…10 and so on, with out_ready=1 and OUT_W=32. Required: rng_update in cycle 1; out_valid in cycle 3; slices 89ABCDEF, 01234567, … in LSB-first order.
- out_ready=0 with distinct words. Required: level saturates at 4, no rng_update once level+inflight=4; releasing ready drains 16 slices in order with no loss or duplication.
- Stub repeats 128'hA5A5…A5 three times with REP_LIMIT=3. Required: fail=1 the cycle after the third CAPT; only 2 entries pushed; rng_update stays 0 afterwards; the 2 entries still drain.
- flush asserted during CAPT with level=2. Required: next cycle level=0, out_valid=0, the captured word is dropped and fetching resumes.
- out_ready toggling every cycle, plus a push and a pop in the same cycle. Required: level is unchanged on that cycle and the slice order is preserved across the pop boundary.
- rst asserted mid-REQ. Required: rng_update=0 immediately and all outputs at reset values; after release the cycle 1 request timing is repeated.
